// File: rtl/uart_baud_if.sv
// Handshake bundle between a UART baud generator and its consumers.
// The generator uses the slave modport. The controlling logic or bench uses master.
interface uart_baud_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 en;
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_in;
  logic                 phase_clr;
  logic                 rx_tick;
  logic                 tx_tick;
  logic                 baud_clk;
  logic [DIV_WIDTH-1:0] active_div;
  logic                 div_err;

  modport master (
    output en, div_load, div_in, phase_clr,
    input  rx_tick, tx_tick, baud_clk, active_div, div_err
  );

  modport slave (
    input  en, div_load, div_in, phase_clr,
    output rx_tick, tx_tick, baud_clk, active_div, div_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// UART baud generator: a runtime divisor sets the oversample strobe (rx_tick).
// A fixed ratio of oversample strobes gives the bit strobe (tx_tick) and a 50 % baud clock.
module uart_baud_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 54
) (
  input logic         clk,
  input logic         rst,
  uart_baud_if.slave  bus
);
  localparam int PH_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0] r_os_cnt;
  logic [PH_W-1:0]      r_ph_cnt;
  logic                 r_rx_tick;
  logic                 r_tx_tick;
  logic                 r_baud_clk;
  logic [DIV_WIDTH-1:0] r_active_div;
  logic                 r_div_err;

  logic [DIV_WIDTH-1:0] w_div_m1;
  logic                 w_div_ok;

  assign w_div_m1 = r_active_div - DIV_WIDTH'(1);
  assign w_div_ok = (bus.div_in > DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_os_cnt     <= '0;
      r_ph_cnt     <= '0;
      r_rx_tick    <= 1'b0;
      r_tx_tick    <= 1'b0;
      r_baud_clk   <= 1'b0;
      r_active_div <= DIV_WIDTH'(DEFAULT_DIV);
      r_div_err    <= 1'b0;
    end else begin
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
      if (bus.div_load && w_div_ok) begin
        r_active_div <= bus.div_in;
        r_os_cnt     <= '0;
        r_ph_cnt     <= '0;
        r_baud_clk   <= 1'b0;
      end else if (bus.phase_clr && !bus.div_load) begin
        r_os_cnt   <= '0;
        r_ph_cnt   <= '0;
        r_baud_clk <= 1'b0;
      end else begin
        // A rejected load only raises the error flag; counting proceeds as if no load occurred.
        if (bus.div_load) begin
          r_div_err <= 1'b1;
        end
        if (bus.en) begin
          if (r_os_cnt == w_div_m1) begin
            r_os_cnt  <= '0;
            r_rx_tick <= 1'b1;
            if (r_ph_cnt == PH_LAST) begin
              r_ph_cnt   <= '0;
              r_tx_tick  <= 1'b1;
              r_baud_clk <= 1'b0;
            end else begin
              r_ph_cnt <= r_ph_cnt + PH_W'(1);
              if (r_ph_cnt == PH_HALF) begin
                r_baud_clk <= 1'b1;
              end
            end
          end else begin
            r_os_cnt <= r_os_cnt + DIV_WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.rx_tick    = r_rx_tick;
  assign bus.tx_tick    = r_tx_tick;
  assign bus.baud_clk   = r_baud_clk;
  assign bus.active_div = r_active_div;
  assign bus.div_err    = r_div_err;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: a per-cycle vector table plus long
// sequences checked against a closed-form schedule of enabled-cycle counts.
module tb_uart_baud_gen;
  localparam int DW = 16;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_baud_if #(.DIV_WIDTH(DW)) bus ();

  uart_baud_gen #(.DIV_WIDTH(DW), .OVERSAMPLE(OS), .DEFAULT_DIV(54)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          en;
    logic          ld;
    logic [DW-1:0] din;
    logic          pc;
    logic          rx;
    logic          tx;
    logic          baud;
    logic [DW-1:0] ad;
    logic          err;
  } vec_t;

  vec_t tbl [21];
  int   n_vec = 0;
  int   n_bad = 0;
  int   e_cnt;
  int   dv;
  logic exp_err;

  task automatic cmp(input string nm, input logic rx, input logic tx, input logic baud,
                     input logic [DW-1:0] ad, input logic err);
    n_vec++;
    if (bus.rx_tick !== rx || bus.tx_tick !== tx || bus.baud_clk !== baud ||
        bus.active_div !== ad || bus.div_err !== err) begin
      n_bad++;
      $display("FAIL %s: got rx=%b tx=%b baud=%b div=%0d err=%b, want rx=%b tx=%b baud=%b div=%0d err=%b",
               nm, bus.rx_tick, bus.tx_tick, bus.baud_clk, bus.active_div, bus.div_err,
               rx, tx, baud, ad, err);
    end
  endtask

  task automatic set_in(input logic en, input logic ld, input logic [DW-1:0] din, input logic pc);
    bus.en = en; bus.div_load = ld; bus.div_in = din; bus.phase_clr = pc;
  endtask

  // One clock with the current inputs, checked against the enabled-cycle schedule.
  task automatic step_check(input string nm);
    logic erx, etx, ebaud;
    if (bus.en) e_cnt++;
    @(posedge clk);
    erx   = bus.en && (e_cnt % dv == 0);
    etx   = bus.en && (e_cnt % (dv * OS) == 0);
    ebaud = ((e_cnt / dv) % OS) >= (OS / 2);
    @(negedge clk);
    cmp(nm, erx, etx, ebaud, DW'(dv), exp_err);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    set_in(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cmp(nm, 1'b0, 1'b0, 1'b0, DW'(54), 1'b0);
    rst = 1'b0;
    e_cnt = 0; dv = 54; exp_err = 1'b0;
  endtask

  task automatic valid_load(input string nm, input int d, input logic pc);
    set_in(1'b1, 1'b1, DW'(d), pc);
    @(posedge clk);
    @(negedge clk);
    cmp(nm, 1'b0, 1'b0, 1'b0, DW'(d), exp_err);
    e_cnt = 0; dv = d;
    set_in(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    //          en  ld  din  pc  rx  tx  bd  ad  err
    tbl[0]  = '{1, 1, 4, 0, 0, 0, 0, 4, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 0, 4, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 4, 0};
    tbl[9]  = '{1, 1, 1, 0, 0, 0, 0, 4, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 0, 0, 4, 1};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 0, 4, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 4, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 4, 1};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 4, 1};
    tbl[15] = '{1, 0, 0, 0, 1, 0, 0, 4, 1};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 0, 4, 1};
    tbl[17] = '{1, 1, 3, 1, 0, 0, 0, 3, 1};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 0, 3, 1};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0, 3, 1};
    tbl[20] = '{1, 0, 0, 0, 1, 0, 0, 3, 1};

    set_in(1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_state", 1'b0, 1'b0, 1'b0, DW'(54), 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].en, tbl[i].ld, tbl[i].din, tbl[i].pc);
      @(posedge clk);
      @(negedge clk);
      cmp($sformatf("vec%0d", i), tbl[i].rx, tbl[i].tx, tbl[i].baud, tbl[i].ad, tbl[i].err);
    end

    do_reset("reset_clears_err");

    // Default divisor: two full bit periods.
    set_in(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 1800; i++) step_check("default_run");

    // Enable low for 100 cycles mid-count; schedule shifts by the idle time.
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) step_check("en_low_hold");
    set_in(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 200; i++) step_check("en_resume");

    // Advance until baud_clk is high and the next edge would produce a tick.
    for (int i = 0; i < 1000; i++) begin
      if (((e_cnt / dv) % OS) >= (OS / 2) && ((e_cnt + 1) % dv == 0)) break;
      step_check("seek_tick");
    end
    if (bus.baud_clk !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL seek_tick_bound: got baud=%b, want 1 before reset", bus.baud_clk);
    end
    do_reset("reset_mid_tick");
    for (int i = 0; i < 60; i++) step_check("after_reset");

    // Load with simultaneous phase clear, 300 cycles into a bit.
    e_cnt = 0;
    do_reset("reset_pre_load");
    for (int i = 0; i < 300; i++) step_check("pre_load10");
    valid_load("load10_with_clr", 10, 1'b1);
    for (int i = 0; i < 170; i++) step_check("div10_run");

    for (int i = 0; i < 7; i++) step_check("pre_load4");
    valid_load("load4_mid", 4, 1'b0);
    for (int i = 0; i < 130; i++) step_check("div4_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
